// File: rtl/ce_obuf_pkg.sv
// Shared types and constants for the output-buffer configuration master:
// FSM state encoding, AXI response code and error classification.
package ce_obuf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        RADDR,
        RDATA,
        CHECK,
        FINISH
    } state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BRESP   = 2'd1;
    localparam logic [1:0] ERR_RDATA   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/ce_obuf_phase_timer.sv
// Per-phase watchdog: cleared on load, counts while enabled, flags expiry
// in the TIMEOUT-th cycle of a phase.
module ce_obuf_phase_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count,
    output logic expire
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    assign expire = count && (cnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (count && !expire) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ce_obuf_cfg_master.sv
// AXI4-Lite master that writes a register image one word at a time and
// reads each word back to verify it, reporting sticky done/err status.
module ce_obuf_cfg_master
    import ce_obuf_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS           = 4,
    parameter int TIMEOUT            = 1024
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   base_addr,
    input  logic [NUM_REGS*32-1:0]          cfg_data,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [1:0]                      err_code,
    output logic [3:0]                      err_idx,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [3:0]                      M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;

    state_t                 state_q, state_d;
    logic [3:0]             idx_q, idx_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [DW-1:0]          wdata_q, wdata_d;
    logic [DW-1:0]          rdata_q, rdata_d;
    logic [NUM_REGS*32-1:0] cfg_q, cfg_d;
    logic                   awvalid_q, awvalid_d;
    logic                   wvalid_q, wvalid_d;
    logic                   bready_q, bready_d;
    logic                   arvalid_q, arvalid_d;
    logic                   rready_q, rready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [1:0]             err_code_q, err_code_d;
    logic [3:0]             err_idx_q, err_idx_d;

    logic       aw_ok, w_ok;
    logic       fin;
    logic [1:0] fin_code;
    logic       timed;
    logic       phase_load;
    logic       tmo;

    assign timed      = (state_q == WRITE) || (state_q == WRESP) ||
                        (state_q == RADDR) || (state_q == RDATA);
    assign phase_load = (state_d != state_q);

    ce_obuf_phase_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (ACLK),
        .rst_n  (ARESETN),
        .load   (phase_load),
        .count  (timed),
        .expire (tmo)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        cfg_d      = cfg_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        err_idx_d  = err_idx_q;
        aw_ok      = !awvalid_q || M_AXI_AWREADY;
        w_ok       = !wvalid_q || M_AXI_WREADY;
        fin        = 1'b0;
        fin_code   = ERR_NONE;

        case (state_q)
            IDLE: begin
                if (start && !busy_q) begin
                    state_d    = WRITE;
                    cfg_d      = cfg_data;
                    idx_d      = 4'd0;
                    addr_d     = base_addr;
                    wdata_d    = cfg_data[31:0];
                    awvalid_d  = 1'b1;
                    wvalid_d   = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                    err_idx_d  = 4'd0;
                end
            end
            WRITE: begin
                // AW and W complete independently; leave only when both have.
                if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
                if (aw_ok && w_ok) begin
                    state_d  = WRESP;
                    bready_d = 1'b1;
                end else if (tmo) begin
                    fin      = 1'b1;
                    fin_code = ERR_TIMEOUT;
                end
            end
            WRESP: begin
                if (M_AXI_BVALID) begin
                    bready_d = 1'b0;
                    if (M_AXI_BRESP == RESP_OKAY) begin
                        state_d   = RADDR;
                        arvalid_d = 1'b1;
                    end else begin
                        fin      = 1'b1;
                        fin_code = ERR_BRESP;
                    end
                end else if (tmo) begin
                    fin      = 1'b1;
                    fin_code = ERR_TIMEOUT;
                end
            end
            RADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RDATA;
                end else if (tmo) begin
                    fin      = 1'b1;
                    fin_code = ERR_TIMEOUT;
                end
            end
            RDATA: begin
                if (M_AXI_RVALID) begin
                    rready_d = 1'b0;
                    rdata_d  = M_AXI_RDATA;
                    if (M_AXI_RRESP == RESP_OKAY) begin
                        state_d = CHECK;
                    end else begin
                        fin      = 1'b1;
                        fin_code = ERR_RDATA;
                    end
                end else if (tmo) begin
                    fin      = 1'b1;
                    fin_code = ERR_TIMEOUT;
                end
            end
            CHECK: begin
                if (rdata_q != cfg_q[32*int'(idx_q) +: 32]) begin
                    fin      = 1'b1;
                    fin_code = ERR_RDATA;
                end else if (idx_q == 4'(NUM_REGS - 1)) begin
                    fin = 1'b1;
                end else begin
                    state_d   = WRITE;
                    idx_d     = idx_q + 4'd1;
                    addr_d    = addr_q + AW'(4);
                    wdata_d   = cfg_q[32*int'(idx_q + 4'd1) +: 32];
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Every exit path funnels here so status and channel teardown stay consistent.
        if (fin) begin
            state_d   = FINISH;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            busy_d    = 1'b0;
            if (fin_code == ERR_NONE) begin
                done_d = 1'b1;
            end else begin
                err_d      = 1'b1;
                err_code_d = fin_code;
                err_idx_d  = idx_q;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            cfg_q      <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            err_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            cfg_q      <= cfg_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            err_idx_q  <= err_idx_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign err_code      = err_code_q;
    assign err_idx       = err_idx_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_ce_obuf_cfg_master.sv
// Bench for ce_obuf_cfg_master: behavioural AXI4-Lite slave with
// programmable stalls and fault injection, checked against a scoreboard.
module tb_ce_obuf_cfg_master;

    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  base_addr = '0;
    logic [127:0] cfg_data = '0;
    logic         busy, done, err;
    logic [1:0]   err_code;
    logic [3:0]   err_idx;
    logic [31:0]  M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
    logic [2:0]   M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]   M_AXI_WSTRB;
    logic         M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
    logic         M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_BVALID = 1'b0;
    logic         M_AXI_ARREADY = 1'b0, M_AXI_RVALID = 1'b0;
    logic [1:0]   M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
    logic [31:0]  M_AXI_RDATA = '0;

    always #5 ACLK = ~ACLK;

    ce_obuf_cfg_master #(
        .C_M_AXI_ADDR_WIDTH (32),
        .C_M_AXI_DATA_WIDTH (32),
        .NUM_REGS           (4),
        .TIMEOUT            (16)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .start         (start),
        .base_addr     (base_addr),
        .cfg_data      (cfg_data),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .err_code      (err_code),
        .err_idx       (err_idx),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWPROT  (M_AXI_AWPROT),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARPROT  (M_AXI_ARPROT),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic       done;
        logic       err;
        logic [1:0] code;
        logic [3:0] idx;
        int         cycles;
    } res_t;

    wr_t   exp_wr_q[$];
    res_t  exp_res_q[$];
    int    n_cmp = 0;
    int    n_mis = 0;
    string cur_test = "init";

    // slave configuration and observation
    logic [31:0] cur_base = '0;
    int          aw_delay = 0, w_delay = 0;
    int          bad_b_idx = -1, bad_r_idx = -1, block_ar_idx = -1;
    int          aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0;
    int          ar_cnt[16];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", cur_test, tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] reg_idx(input logic [31:0] a);
        logic [31:0] d;
        d = a - cur_base;
        return d[5:2];
    endfunction

    // Behavioural slave: samples handshakes at the edge, updates 1 time unit later.
    initial begin
        logic        hs_aw, hs_w, hs_b, hs_ar, hs_r;
        logic [31:0] s_awaddr, s_wdata, s_araddr, smp_aw, smp_w, smp_ar;
        logic        aw_got, w_got, b_pend, r_pend;
        int          aw_cnt, w_cnt;
        logic [31:0] mem[16];
        wr_t         e;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; aw_cnt = 0; w_cnt = 0;
        s_awaddr = '0; s_wdata = '0; s_araddr = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        forever begin
            @(posedge ACLK);
            hs_aw  = M_AXI_AWVALID && M_AXI_AWREADY;
            hs_w   = M_AXI_WVALID && M_AXI_WREADY;
            hs_b   = M_AXI_BVALID && M_AXI_BREADY;
            hs_ar  = M_AXI_ARVALID && M_AXI_ARREADY;
            hs_r   = M_AXI_RVALID && M_AXI_RREADY;
            smp_aw = M_AXI_AWADDR;
            smp_w  = M_AXI_WDATA;
            smp_ar = M_AXI_ARADDR;
            #1;
            if (!ARESETN) begin
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; aw_cnt = 0; w_cnt = 0;
                M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
                M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
            end else begin
                if (hs_aw) begin aw_got = 1; s_awaddr = smp_aw; aw_hs_n++; end
                if (hs_w)  begin w_got = 1; s_wdata = smp_w; w_hs_n++; end
                if (hs_b)  begin M_AXI_BVALID = 0; b_hs_n++; end
                if (hs_r)  M_AXI_RVALID = 0;
                if (b_pend) begin
                    M_AXI_BVALID = 1;
                    M_AXI_BRESP  = (int'(reg_idx(s_awaddr)) == bad_b_idx) ? 2'b10 : 2'b00;
                    b_pend = 0;
                end
                if (r_pend) begin
                    M_AXI_RVALID = 1;
                    M_AXI_RRESP  = 2'b00;
                    M_AXI_RDATA  = (int'(reg_idx(s_araddr)) == bad_r_idx) ? 32'hdead0010
                                                                         : mem[reg_idx(s_araddr)];
                    r_pend = 0;
                end
                if (hs_ar) begin
                    r_pend = 1;
                    s_araddr = smp_ar;
                    ar_cnt[reg_idx(smp_ar)]++;
                end
                if (aw_got && w_got) begin
                    if (exp_wr_q.size() == 0) begin
                        check_val("wr_extra", 64'(exp_wr_q.size()), 64'd1);
                    end else begin
                        e = exp_wr_q.pop_front();
                        check_val("wr_addr", 64'(s_awaddr), 64'(e.a));
                        check_val("wr_data", 64'(s_wdata), 64'(e.d));
                    end
                    mem[reg_idx(s_awaddr)] = s_wdata;
                    b_pend = 1; aw_got = 0; w_got = 0;
                end
                if (M_AXI_AWVALID && !aw_got) begin
                    M_AXI_AWREADY = (aw_cnt >= aw_delay); aw_cnt++;
                end else begin
                    M_AXI_AWREADY = 0; aw_cnt = 0;
                end
                if (M_AXI_WVALID && !w_got) begin
                    M_AXI_WREADY = (w_cnt >= w_delay); w_cnt++;
                end else begin
                    M_AXI_WREADY = 0; w_cnt = 0;
                end
                M_AXI_ARREADY = M_AXI_ARVALID && (int'(reg_idx(M_AXI_ARADDR)) != block_ar_idx);
            end
        end
    end

    task automatic start_seq(input logic [31:0] base, input logic [127:0] data,
                             input int n_wr, input res_t r);
        wr_t w;
        cur_base  = base;
        base_addr = base;
        cfg_data  = data;
        for (int i = 0; i < n_wr; i++) begin
            w.a = base + 32'(4 * i);
            w.d = data[32*i +: 32];
            exp_wr_q.push_back(w);
        end
        exp_res_q.push_back(r);
        aw_hs_n = 0; w_hs_n = 0; b_hs_n = 0;
        for (int i = 0; i < 16; i++) ar_cnt[i] = 0;
        @(posedge ACLK); #1 start = 1'b1;
        @(posedge ACLK); #1 start = 1'b0;
        check_val("busy_on", 64'(busy), 64'd1);
        check_val("done_clr", 64'(done), 64'd0);
        check_val("err_clr", 64'(err), 64'd0);
    endtask

    task automatic wait_seq(input bit poke);
        int   cyc;
        bit   seen;
        res_t r;
        cyc = 0; seen = 0;
        while (cyc < 300 && !seen) begin
            @(posedge ACLK); #1;
            cyc++;
            if (poke && cyc == 5) begin base_addr = 32'h5000; start = 1'b1; end
            if (poke && cyc == 6) start = 1'b0;
            if (done || err) seen = 1;
        end
        check_val("finish_seen", 64'(done || err), 64'd1);
        if (exp_res_q.size() == 0) begin
            check_val("res_q", 64'(exp_res_q.size()), 64'd1);
        end else begin
            r = exp_res_q.pop_front();
            check_val("cycles", 64'(cyc), 64'(r.cycles));
            check_val("done", 64'(done), 64'(r.done));
            check_val("err", 64'(err), 64'(r.err));
            check_val("err_code", 64'(err_code), 64'(r.code));
            if (r.err) check_val("err_idx", 64'(err_idx), 64'(r.idx));
            check_val("busy_off", 64'(busy), 64'd0);
            @(posedge ACLK); #1;
            check_val("done_sticky", 64'(done), 64'(r.done));
            check_val("err_sticky", 64'(err), 64'(r.err));
        end
        check_val("wr_missing", 64'(exp_wr_q.size()), 64'd0);
    endtask

    function automatic res_t mk(input logic d, input logic e, input logic [1:0] c,
                                input logic [3:0] i, input int cy);
        res_t r;
        r.done = d; r.err = e; r.code = c; r.idx = i; r.cycles = cy;
        return r;
    endfunction

    localparam logic [127:0] IMG = {32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101FFFF};

    initial begin
        int k;
        repeat (3) @(posedge ACLK);
        #1;
        cur_test = "reset";
        check_val("busy", 64'(busy), 64'd0);
        check_val("done", 64'(done), 64'd0);
        check_val("err", 64'(err), 64'd0);
        check_val("awvalid", 64'(M_AXI_AWVALID), 64'd0);
        check_val("awaddr", 64'(M_AXI_AWADDR), 64'd0);
        check_val("wstrb", 64'(M_AXI_WSTRB), 64'hF);
        check_val("prot", 64'({M_AXI_AWPROT, M_AXI_ARPROT}), 64'd0);
        ARESETN = 1'b1;
        repeat (2) @(posedge ACLK);

        cur_test = "zero_wait";
        start_seq(32'h0, IMG, 4, mk(1, 0, 2'd0, 4'd0, 28));
        wait_seq(0);
        check_val("aw_hs", 64'(aw_hs_n), 64'd4);
        check_val("b_hs", 64'(b_hs_n), 64'd4);

        cur_test = "aw_slow";
        aw_delay = 3;
        start_seq(32'h0, IMG, 4, mk(1, 0, 2'd0, 4'd0, 40));
        wait_seq(0);
        check_val("aw_hs", 64'(aw_hs_n), 64'd4);
        check_val("w_hs", 64'(w_hs_n), 64'd4);
        check_val("b_hs", 64'(b_hs_n), 64'd4);
        aw_delay = 0;

        cur_test = "w_slow";
        w_delay = 3;
        start_seq(32'h0, IMG, 4, mk(1, 0, 2'd0, 4'd0, 40));
        wait_seq(0);
        check_val("aw_hs", 64'(aw_hs_n), 64'd4);
        check_val("w_hs", 64'(w_hs_n), 64'd4);
        check_val("b_hs", 64'(b_hs_n), 64'd4);
        w_delay = 0;

        cur_test = "bresp_err";
        bad_b_idx = 2;
        start_seq(32'h0, IMG, 3, mk(0, 1, 2'd1, 4'd2, 17));
        wait_seq(0);
        check_val("ar_idx2", 64'(ar_cnt[2]), 64'd0);
        bad_b_idx = -1;

        cur_test = "rdata_err";
        bad_r_idx = 2;
        start_seq(32'h0, IMG, 3, mk(0, 1, 2'd2, 4'd2, 21));
        wait_seq(0);
        bad_r_idx = -1;

        cur_test = "ar_timeout";
        block_ar_idx = 1;
        start_seq(32'h0, IMG, 2, mk(0, 1, 2'd3, 4'd1, 26));
        wait_seq(0);
        check_val("arvalid_drop", 64'(M_AXI_ARVALID), 64'd0);
        block_ar_idx = -1;

        cur_test = "wrap";
        start_seq(32'hFFFF_FFF8, IMG, 4, mk(1, 0, 2'd0, 4'd0, 28));
        wait_seq(0);

        cur_test = "mid_reset";
        start_seq(32'h0, IMG, 4, mk(1, 0, 2'd0, 4'd0, 28));
        k = 0;
        while (k < 50 && !M_AXI_BREADY) begin
            @(posedge ACLK); #1;
            k++;
        end
        check_val("bready_seen", 64'(M_AXI_BREADY), 64'd1);
        #2 ARESETN = 1'b0;
        #1;
        check_val("busy", 64'(busy), 64'd0);
        check_val("status", 64'({done, err, err_code, err_idx}), 64'd0);
        check_val("valids", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                                  M_AXI_ARVALID, M_AXI_RREADY}), 64'd0);
        check_val("awaddr", 64'(M_AXI_AWADDR), 64'd0);
        check_val("wdata", 64'(M_AXI_WDATA), 64'd0);
        check_val("araddr", 64'(M_AXI_ARADDR), 64'd0);
        exp_wr_q.delete();
        exp_res_q.delete();
        repeat (2) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        repeat (4) @(posedge ACLK);
        #1;
        check_val("no_replay", 64'({busy, M_AXI_AWVALID, M_AXI_WVALID}), 64'd0);

        cur_test = "after_reset";
        start_seq(32'h100, IMG, 4, mk(1, 0, 2'd0, 4'd0, 28));
        wait_seq(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ce_obuf_cfg_master.md
CE_OBUF_CFG_MASTER -- requirements
Module: ce_obuf_cfg_master

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, AXI4-Lite address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, data width; 32 is the only supported value.
REQ-003 SHALL have parameter NUM_REGS, default 4, number of registers to configure (1..16).
REQ-004 SHALL have parameter TIMEOUT, default 1024, maximum cycles waited per handshake phase.
REQ-005 SHALL have port ACLK, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port ARESETN, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, one-cycle pulse that starts a configure-and-verify sequence.
REQ-008 SHALL have port base_addr, input, C_M_AXI_ADDR_WIDTH, address of register 0, sampled on accepted start.
REQ-009 SHALL have port cfg_data, input, NUM_REGS*32, flat register image with reg i at bits [32i+31:32i], sampled on accepted start.
REQ-010 SHALL have port busy, output, 1, high from the accepted start until done or err.
REQ-011 SHALL have ports done and err, output, 1 each; sticky status, cleared by the next accepted start.
REQ-012 SHALL have port err_code, output, 2: 1 = non-OKAY BRESP, 2 = non-OKAY RRESP or readback mismatch, 3 = timeout.
REQ-013 SHALL have port err_idx, output, 4, index of the register that failed.
REQ-014 SHALL have AW channel ports M_AXI_AWADDR (out), M_AXI_AWPROT (out, 3, constant 0), M_AXI_AWVALID (out) and M_AXI_AWREADY (in).
REQ-015 SHALL have W channel ports M_AXI_WDATA (out), M_AXI_WSTRB (out, 4, constant 4'hF), M_AXI_WVALID (out) and M_AXI_WREADY (in).
REQ-016 SHALL have B channel ports M_AXI_BRESP (in, 2), M_AXI_BVALID (in) and M_AXI_BREADY (out).
REQ-017 SHALL have AR channel ports M_AXI_ARADDR (out), M_AXI_ARPROT (out, constant 0), M_AXI_ARVALID (out) and M_AXI_ARREADY (in).
REQ-018 SHALL have R channel ports M_AXI_RDATA (in), M_AXI_RRESP (in, 2), M_AXI_RVALID (in) and M_AXI_RREADY (out).

Function
REQ-019 SHALL implement states IDLE, WRITE, WRESP, RADDR, RDATA, CHECK and FINISH.
REQ-020 IDLE: start with busy low SHALL latch base_addr and cfg_data, set idx=0, clear done/err and enter WRITE next cycle; start while busy SHALL be ignored.
REQ-021 WRITE: AWVALID and WVALID SHALL assert together, with AWADDR = base+4*idx and WDATA = cfg_data[idx].
REQ-022 WRITE: each VALID SHALL drop independently on its own handshake (either order, or the same cycle), and the FSM SHALL go to WRESP once both channels have completed.
REQ-023 WRESP: BREADY SHALL be high; on BVALID, BRESP==OKAY SHALL go to RADDR, and any other BRESP SHALL go to FINISH with err_code=1.
REQ-024 RADDR: ARVALID SHALL be high with ARADDR = the same address as the write, until ARREADY, then the FSM SHALL go to RDATA.
REQ-025 RDATA: RREADY SHALL be high; on RVALID, RDATA SHALL be captured and the FSM SHALL go to CHECK; a non-OKAY RRESP SHALL give err_code=2.
REQ-026 CHECK: if captured data equals cfg_data[idx], the FSM SHALL go to WRITE with idx+1, or to FINISH when idx==NUM_REGS-1; on mismatch it SHALL go to FINISH with err_code=2.
REQ-027 Every phase (WRITE, WRESP, RADDR, RDATA) SHALL restart a cycle counter on entry; reaching TIMEOUT SHALL deassert all VALID/READY and go to FINISH with err_code=3.
REQ-028 FINISH: in one cycle, busy SHALL drop, exactly one of done/err SHALL set, err_idx SHALL equal idx on error, and the FSM SHALL return to IDLE.
REQ-029 Once asserted, a VALID SHALL NOT drop or change its payload before its handshake, except on timeout.
REQ-030 Address arithmetic SHALL be modulo 2^C_M_AXI_ADDR_WIDTH (wrap-around allowed), and at most one transaction SHALL be outstanding.
REQ-031 Per-register latency with zero-wait slave SHALL be 7 cycles (WRITE 1, WRESP 2, RADDR 1, RDATA 2, CHECK 1).

Reset
REQ-032 ARESETN low SHALL immediately force IDLE, clear all VALID/READY, busy, done, err, err_code, err_idx and idx, and zero the address/data outputs.
REQ-033 A reset mid-transaction SHALL abandon the transaction with no replay after reset release.

Structure
REQ-034 Package ce_obuf_pkg SHALL hold the state enum, the RESP_OKAY=2'b00 constant and the err_code constants.
REQ-035 Sub-module ce_obuf_phase_timer (load/count/expire, TIMEOUT-wide) SHALL be instantiated once.

Verification
REQ-036 Zero-wait slave, base 0x0, data {0101FFFF, abcd0001, dead0011, beef0011} -> writes to 0x0/0x4/0x8/0xC, done=1 after 28 cycles, err=0.
REQ-037 WREADY 3 cycles before AWREADY, and the reverse -> each channel handshakes once, BREADY is reached exactly once per register.
REQ-038 Slave returns BRESP=2'b10 on idx 2 -> err=1, err_code=1, err_idx=2, no AR issued for idx 2.
REQ-039 Slave returns corrupted RDATA 0xdead0010 on idx 2 -> err_code=2, err_idx=2; ARREADY held low on idx 1 with TIMEOUT=16 -> err_code=3, err_idx=1 after 16 cycles.
REQ-040 ARESETN low during WRESP, then start re-pulsed -> all outputs zero during reset, new sequence completes from idx 0; start while busy -> ignored.
